// File: rtl/uart_fifo.sv
// Buffered 6502-bus window onto the UART core: TX and RX byte FIFOs,
// a drain FSM feeding the core's load handshake, and a 4-register map.
module uart_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cs,
   input  logic       we,
   input  logic [1:0] addr,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       tx_load,
   output logic [7:0] tx_data,
   input  logic       tx_busy,
   input  logic       rx_valid,
   input  logic [7:0] rx_data
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   CNT_FULL = DEPTH[DEPTH_LOG2:0];
   localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;

   typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_IDLE} state_t;

   state_t state, next;

   logic [7:0] tx_mem [DEPTH];
   logic [7:0] rx_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr;
   logic [DEPTH_LOG2:0]   tx_cnt, rx_cnt;
   logic tx_ovf, rx_ovf;
   logic tx_pop, tx_push, rx_pop, rx_push;
   logic wr0, rd0, rd1;
   logic tx_full, rx_full, tx_empty, rx_avail;
   logic [7:0] status, rd_data;

   assign wr0 = cs && we && (addr == 2'd0);
   assign rd0 = cs && !we && (addr == 2'd0);
   assign rd1 = cs && !we && (addr == 2'd1);

   assign tx_full  = (tx_cnt == CNT_FULL);
   assign rx_full  = (rx_cnt == CNT_FULL);
   assign rx_avail = (rx_cnt != '0);
   assign tx_empty = (tx_cnt == '0) && (state == IDLE) && !tx_busy;

   // A full FIFO still accepts a push when a pop frees a slot this cycle
   assign tx_push = wr0 && (!tx_full || tx_pop);
   assign rx_pop  = rd0 && rx_avail;
   assign rx_push = rx_valid && (!rx_full || rx_pop);

   assign status = {3'b000, tx_ovf, rx_ovf, tx_empty, rx_avail, tx_full};

   always_comb begin
      next    = state;
      tx_load = 1'b0;
      tx_pop  = 1'b0;
      unique case (state)
         IDLE: begin
            if ((tx_cnt != '0) && !tx_busy) begin
               tx_pop = 1'b1;
               next   = LOAD;
            end
         end
         LOAD: begin
            tx_load = 1'b1;
            next    = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (tx_busy) next = WAIT_IDLE;
         end
         WAIT_IDLE: begin
            if (!tx_busy) next = IDLE;
         end
         default: next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next;
   end

   always_comb begin
      rd_data = 8'h00;
      unique case (addr)
         2'd0: rd_data = rx_avail ? rx_mem[rx_rptr] : 8'h00;
         2'd1: rd_data = status;
         2'd2: rd_data = 8'(rx_cnt);
         2'd3: rd_data = 8'(tx_cnt);
         default: rd_data = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wptr] <= din;
      if (rx_push) rx_mem[rx_wptr] <= rx_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_wptr <= '0;
         tx_rptr <= '0;
         tx_cnt  <= '0;
         rx_wptr <= '0;
         rx_rptr <= '0;
         rx_cnt  <= '0;
         tx_ovf  <= 1'b0;
         rx_ovf  <= 1'b0;
         tx_data <= 8'h00;
         dout    <= 8'h00;
      end else begin
         dout <= rd_data;
         if (tx_push) tx_wptr <= tx_wptr + PTR_ONE;
         if (tx_pop) begin
            tx_rptr <= tx_rptr + PTR_ONE;
            tx_data <= tx_mem[tx_rptr];
         end
         if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + CNT_ONE;
         else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - CNT_ONE;
         if (rx_push) rx_wptr <= rx_wptr + PTR_ONE;
         if (rx_pop)  rx_rptr <= rx_rptr + PTR_ONE;
         if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + CNT_ONE;
         else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - CNT_ONE;
         // A new overflow beats a status-read clear in the same cycle
         tx_ovf <= (wr0 && !tx_push) || (tx_ovf && !rd1);
         rx_ovf <= (rx_valid && !rx_push) || (rx_ovf && !rd1);
      end
   end

endmodule

// File: tb/tb_uart_fifo.sv
// Bench for uart_fifo: bus tasks, a UART core model and byte scoreboards
// for the TX load stream and RX read stream.
module tb_uart_fifo;

   logic       clk = 1'b0;
   logic       rst;
   logic       cs;
   logic       we;
   logic [1:0] addr;
   logic [7:0] din;
   logic [7:0] dout;
   logic       tx_load;
   logic [7:0] tx_data;
   logic       tx_busy;
   logic       rx_valid;
   logic [7:0] rx_data;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] tx_exp_q [$];
   logic [7:0] tx_obs_q [$];
   logic [7:0] rx_exp_q [$];
   int loads = 0;

   int  busy_cnt = 0;
   logic hold = 1'b0;
   logic force_busy = 1'b0;

   uart_fifo #(.DEPTH_LOG2(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .cs       (cs),
      .we       (we),
      .addr     (addr),
      .din      (din),
      .dout     (dout),
      .tx_load  (tx_load),
      .tx_data  (tx_data),
      .tx_busy  (tx_busy),
      .rx_valid (rx_valid),
      .rx_data  (rx_data)
   );

   always #5 clk = ~clk;

   // Core model: busy for 10 cycles per byte; hold freezes the countdown
   always @(posedge clk) begin
      if (tx_load) busy_cnt <= 10;
      else if (busy_cnt != 0 && !hold) busy_cnt <= busy_cnt - 1;
   end
   assign tx_busy = (busy_cnt != 0) || force_busy;

   always @(negedge clk) begin
      if (tx_load) begin
         tx_obs_q.push_back(tx_data);
         loads <= loads + 1;
      end
   end

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      cs = 1'b1; we = 1'b1; addr = a; din = d;
      @(posedge clk);
      #1 cs = 1'b0; we = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [7:0] d);
      @(negedge clk);
      cs = 1'b1; we = 1'b0; addr = a;
      @(negedge clk);
      d = dout;
      cs = 1'b0;
   endtask

   task automatic rx_inject(input logic [7:0] d);
      @(negedge clk);
      rx_valid = 1'b1; rx_data = d;
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0] v;
      logic [7:0] exp_r [3];
      rst = 1'b1; cs = 1'b0; we = 1'b0; addr = 2'd0; din = 8'h00;
      rx_valid = 1'b0; rx_data = 8'h00;
      repeat (3) @(negedge clk);
      vectors++;
      if (dout !== 8'h00 || tx_data !== 8'h00 || tx_load !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_outputs: dout=%h tx_data=%h tx_load=%b want 00 00 0",
                  dout, tx_data, tx_load);
      end
      rst = 1'b0;
      exp_r[0] = 8'h04; exp_r[1] = 8'h00; exp_r[2] = 8'h00;
      for (int i = 0; i < 3; i++) begin
         rd(2'(i + 1), v);
         vectors++;
         if (v !== exp_r[i]) begin
            miscompares++;
            $display("FAIL reset_addr%0d: got %h want %h", i + 1, v, exp_r[i]);
         end
      end
      vectors++;
      if (loads !== 0) begin
         miscompares++;
         $display("FAIL reset_no_load: got %0d loads want 0", loads);
      end
   endtask

   task automatic test_tx_basic();
      logic [7:0] v;
      logic [7:0] e;
      bit done = 0;
      for (int i = 0; i < 3; i++) begin
         tx_exp_q.push_back(8'h41 + 8'(i));
         wr(2'd0, 8'h41 + 8'(i));
      end
      for (int t = 0; t < 200 && !done; t++) begin
         rd(2'd1, v);
         if (v[2] && loads == 3) done = 1;
      end
      vectors++;
      if (!done) begin
         miscompares++;
         $display("FAIL tx_basic_drain: loads=%0d status=%h want 3 loads, bit2=1", loads, v);
      end
      vectors++;
      if (tx_obs_q.size() != 3) begin
         miscompares++;
         $display("FAIL tx_basic_count: got %0d loads want 3", tx_obs_q.size());
      end
      while (tx_obs_q.size() > 0 && tx_exp_q.size() > 0) begin
         v = tx_obs_q.pop_front();
         e = tx_exp_q.pop_front();
         vectors++;
         if (v !== e) begin
            miscompares++;
            $display("FAIL tx_basic_data: got %h want %h", v, e);
         end
      end
      tx_exp_q.delete();
      tx_obs_q.delete();
   endtask

   task automatic test_rx_overflow();
      logic [7:0] v;
      logic [7:0] e;
      force_busy = 1'b1;
      for (int i = 0; i < 17; i++) begin
         if (i < 16) rx_exp_q.push_back(8'(i));
         rx_inject(8'(i));
      end
      rd(2'd2, v);
      vectors++;
      if (v !== 8'h10) begin
         miscompares++;
         $display("FAIL rx_count_full: got %h want 10", v);
      end
      rd(2'd1, v);
      vectors++;
      if (v !== 8'h0A) begin
         miscompares++;
         $display("FAIL rx_status_ovf: got %h want 0a", v);
      end
      rd(2'd1, v);
      vectors++;
      if (v !== 8'h02) begin
         miscompares++;
         $display("FAIL rx_status_clear: got %h want 02", v);
      end
      for (int i = 0; i < 16; i++) begin
         rd(2'd0, v);
         e = rx_exp_q.pop_front();
         vectors++;
         if (v !== e) begin
            miscompares++;
            $display("FAIL rx_read_%0d: got %h want %h", i, v, e);
         end
      end
      rd(2'd0, v);
      vectors++;
      if (v !== 8'h00) begin
         miscompares++;
         $display("FAIL rx_read_empty: got %h want 00", v);
      end
      rd(2'd2, v);
      vectors++;
      if (v !== 8'h00) begin
         miscompares++;
         $display("FAIL rx_count_empty: got %h want 00", v);
      end
   endtask

   task automatic test_rx_full_concurrent();
      logic [7:0] v;
      logic [7:0] e;
      for (int i = 0; i < 16; i++) begin
         rx_exp_q.push_back(8'h20 + 8'(i));
         rx_inject(8'h20 + 8'(i));
      end
      @(negedge clk);
      cs = 1'b1; we = 1'b0; addr = 2'd0;
      rx_valid = 1'b1; rx_data = 8'h30;
      rx_exp_q.push_back(8'h30);
      @(negedge clk);
      v = dout;
      cs = 1'b0; rx_valid = 1'b0;
      e = rx_exp_q.pop_front();
      vectors++;
      if (v !== e) begin
         miscompares++;
         $display("FAIL rx_conc_head: got %h want %h", v, e);
      end
      rd(2'd2, v);
      vectors++;
      if (v !== 8'h10) begin
         miscompares++;
         $display("FAIL rx_conc_count: got %h want 10", v);
      end
      rd(2'd1, v);
      vectors++;
      if (v !== 8'h02) begin
         miscompares++;
         $display("FAIL rx_conc_status: got %h want 02", v);
      end
      for (int i = 0; i < 16; i++) begin
         rd(2'd0, v);
         e = rx_exp_q.pop_front();
         vectors++;
         if (v !== e) begin
            miscompares++;
            $display("FAIL rx_conc_read_%0d: got %h want %h", i, v, e);
         end
      end
      force_busy = 1'b0;
   endtask

   task automatic test_tx_overflow();
      logic [7:0] v;
      logic [7:0] e;
      int l0;
      bit done = 0;
      l0 = loads;
      hold = 1'b1;
      for (int i = 0; i < 17; i++) begin
         tx_exp_q.push_back(8'h60 + 8'(i));
         wr(2'd0, 8'h60 + 8'(i));
      end
      wr(2'd0, 8'h7F);
      rd(2'd1, v);
      vectors++;
      if (v !== 8'h11) begin
         miscompares++;
         $display("FAIL tx_ovf_status: got %h want 11", v);
      end
      rd(2'd3, v);
      vectors++;
      if (v !== 8'h10) begin
         miscompares++;
         $display("FAIL tx_ovf_count: got %h want 10", v);
      end
      vectors++;
      if (loads !== l0 + 1) begin
         miscompares++;
         $display("FAIL tx_ovf_loads: got %0d want %0d", loads, l0 + 1);
      end
      if (tx_obs_q.size() > 0) begin
         v = tx_obs_q.pop_front();
         e = tx_exp_q.pop_front();
         vectors++;
         if (v !== e) begin
            miscompares++;
            $display("FAIL tx_ovf_first: got %h want %h", v, e);
         end
      end
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      tx_exp_q.delete();
      tx_obs_q.delete();
      hold = 1'b0;
      for (int t = 0; t < 50 && !done; t++) begin
         @(negedge clk);
         if (!tx_busy) done = 1;
      end
      vectors++;
      if (!done) begin
         miscompares++;
         $display("FAIL tx_ovf_busy_fall: busy=%b want 0", tx_busy);
      end
   endtask

   task automatic test_reset_mid_tx();
      logic [7:0] v;
      int l0;
      bit done = 0;
      l0 = loads;
      hold = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tx_exp_q.push_back(8'hA0 + 8'(i));
         wr(2'd0, 8'hA0 + 8'(i));
      end
      for (int t = 0; t < 20 && loads == l0; t++) @(negedge clk);
      repeat (3) @(negedge clk);
      vectors++;
      if (loads !== l0 + 1 || tx_obs_q.size() == 0) begin
         miscompares++;
         $display("FAIL mid_first_load: got %0d loads want %0d", loads, l0 + 1);
      end else begin
         v = tx_obs_q.pop_front();
         vectors++;
         if (v !== tx_exp_q[0]) begin
            miscompares++;
            $display("FAIL mid_first_data: got %h want %h", v, tx_exp_q[0]);
         end
      end
      rd(2'd3, v);
      vectors++;
      if (v !== 8'h05) begin
         miscompares++;
         $display("FAIL mid_queued: got %h want 05", v);
      end
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      tx_exp_q.delete();
      rd(2'd3, v);
      vectors++;
      if (v !== 8'h00) begin
         miscompares++;
         $display("FAIL mid_tx_count: got %h want 00", v);
      end
      rd(2'd2, v);
      vectors++;
      if (v !== 8'h00) begin
         miscompares++;
         $display("FAIL mid_rx_count: got %h want 00", v);
      end
      rd(2'd1, v);
      vectors++;
      if (v[2] !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_empty_while_busy: got %h want bit2=0", v);
      end
      hold = 1'b0;
      for (int t = 0; t < 50 && !done; t++) begin
         @(negedge clk);
         if (!tx_busy) done = 1;
      end
      vectors++;
      if (!done) begin
         miscompares++;
         $display("FAIL mid_busy_fall: busy=%b want 0", tx_busy);
      end
      repeat (30) @(negedge clk);
      vectors++;
      if (loads !== l0 + 1) begin
         miscompares++;
         $display("FAIL mid_no_reload: got %0d loads want %0d", loads, l0 + 1);
      end
      rd(2'd1, v);
      vectors++;
      if (v !== 8'h04) begin
         miscompares++;
         $display("FAIL mid_status_idle: got %h want 04", v);
      end
   endtask

   initial begin
      test_reset();
      test_tx_basic();
      test_rx_overflow();
      test_rx_full_concurrent();
      test_tx_overflow();
      test_reset_mid_tx();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
